// File: rtl/sync_params.sv
// Shared constants for the sync block configuration bus: data/address widths,
// register addresses and the bus master FSM state encoding.
// Latency: none (constants only). Backpressure: none.
package sync_params;

  localparam int MSB              = 31;
  localparam int MSB_REGS_ADDRESS = 7;

  // Register addresses decoded by the sampler register bank.
  localparam logic [MSB_REGS_ADDRESS:0] NUMSAMPLESREG = 8'h04;
  localparam logic [MSB_REGS_ADDRESS:0] SUBVALUEREG   = 8'h05;

  // Bus master FSM encoding.
  typedef logic [1:0] bus_state_t;
  localparam bus_state_t IDLE    = 2'd0;
  localparam bus_state_t WR      = 2'd1;
  localparam bus_state_t RD_WAIT = 2'd2;
  localparam bus_state_t RESP    = 2'd3;

endpackage

// File: rtl/cfg_rdback_or.sv
// Folds the per-bank readback words into one word with a bitwise OR.
// Latency: combinational, zero cycles.
// Backpressure: none; a bank that is not addressed drives zero.
// Ports: rd_bus  - NUM_RD concatenated words, slot i at [(i+1)*W-1 : i*W]
//        rd_word - OR of all slots
module cfg_rdback_or #(
  parameter int NUM_RD = 2,
  parameter int W      = 32
) (
  input  logic [NUM_RD*W-1:0] rd_bus,
  output logic [W-1:0]        rd_word
);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_word = rd_word | rd_bus[i*W +: W];
    end
  end

endmodule

// File: rtl/cfg_bus_master.sv
// Initiator for the register configuration bus: one write or read at a time.
// Latency: write strobe 1 cycle after accept, write response after 2; read response after RD_LATENCY+1.
// Backpressure: req_ready is low from accept until the response handshake; rsp_ready low holds RESP indefinitely.
// Ports: req_*  - command port (valid/ready), rsp_* - response port (valid/ready),
//        cfg_we/cfg_addr/cfg_data_in - bus outputs, cfg_data_out_bus - NUM_RD readback slots.
module cfg_bus_master #(
  parameter int MSB              = sync_params::MSB,
  parameter int MSB_REGS_ADDRESS = sync_params::MSB_REGS_ADDRESS,
  parameter int NUM_RD           = 2,
  parameter int RD_LATENCY       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [MSB_REGS_ADDRESS:0]     req_addr,
  input  logic [MSB:0]                  req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [MSB:0]                  rsp_rdata,
  output logic                          cfg_we,
  output logic [MSB_REGS_ADDRESS:0]     cfg_addr,
  output logic [MSB:0]                  cfg_data_in,
  input  logic [NUM_RD*(MSB+1)-1:0]     cfg_data_out_bus
);

  import sync_params::*;

  localparam int         DW      = MSB + 1;
  localparam logic [2:0] RD_WAIT_INIT = 3'(RD_LATENCY);

  bus_state_t    state;
  bus_state_t    state_nxt;
  logic [2:0]    wait_cnt;
  logic [DW-1:0] rd_word;

  cfg_rdback_or #(
    .NUM_RD (NUM_RD),
    .W      (DW)
  ) u_rdback_or (
    .rd_bus  (cfg_data_out_bus),
    .rd_word (rd_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. RESP never falls straight through to a new accept:
  // the command port only opens once the FSM is back in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_write ? WR : RD_WAIT;
      WR:      state_nxt = RESP;
      RD_WAIT: if (wait_cnt == 3'd1) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only, so a reset edge clears them at once.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    cfg_we    = (state == WR);
  end

  // Bus and response registers. cfg_addr/cfg_data_in are only reloaded on
  // accept, so the bus keeps its last values while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_addr    <= '0;
      cfg_data_in <= '0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cfg_addr    <= req_addr;
            cfg_data_in <= req_wdata;
            rsp_write   <= req_write;
            if (!req_write) wait_cnt <= RD_WAIT_INIT;
          end
        end
        WR: begin
          rsp_rdata <= '0;
        end
        RD_WAIT: begin
          // The last wait cycle is the one where readback is valid.
          if (wait_cnt == 3'd1) rsp_rdata <= rd_word;
          wait_cnt <= wait_cnt - 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bus_master.sv
// Bench for cfg_bus_master: two instances (RD_LATENCY 1 and 3) against a
// transaction-level reference model, with directed literal checks first and
// randomized traffic with random response backpressure afterwards.
module tb_cfg_bus_master;

  import sync_params::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [7:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_write [2];
  logic [31:0] rsp_rdata [2];
  logic        cfg_we    [2];
  logic [7:0]  cfg_addr  [2];
  logic [31:0] cfg_data_in [2];
  logic [63:0] rb_bus    [2];

  cfg_bus_master #(.MSB(31), .MSB_REGS_ADDRESS(7), .NUM_RD(2), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
    .rsp_rdata(rsp_rdata[0]),
    .cfg_we(cfg_we[0]), .cfg_addr(cfg_addr[0]), .cfg_data_in(cfg_data_in[0]),
    .cfg_data_out_bus(rb_bus[0])
  );

  cfg_bus_master #(.MSB(31), .MSB_REGS_ADDRESS(7), .NUM_RD(2), .RD_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
    .rsp_rdata(rsp_rdata[1]),
    .cfg_we(cfg_we[1]), .cfg_addr(cfg_addr[1]), .cfg_data_in(cfg_data_in[1]),
    .cfg_data_out_bus(rb_bus[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit rdy_rand [2];
  int we_cnt   [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t got 0x%08h expected 0x%08h", nm, k, $time, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- register bank environment ----------------
  // Slot 0 answers 0x00-0x3F, slot 1 answers 0x40-0x7F, 0x80-0xFF unmapped.
  // Instance 1 sees readback two cycles late to exercise RD_LATENCY=3.
  logic [31:0] mem [2][256] = '{default: '0};
  logic [7:0]  apipe [2];
  logic [7:0]  rb_addr [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cfg_we[k] === 1'b1) mem[k][cfg_addr[k]] <= cfg_data_in[k];
    end
    apipe[0] <= cfg_addr[1];
    apipe[1] <= apipe[0];
  end

  assign rb_addr[0] = cfg_addr[0];
  assign rb_addr[1] = apipe[1];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rb_bus[k] = '0;
      if (rb_addr[k][7:6] == 2'b00) rb_bus[k][31:0]  = mem[k][rb_addr[k]];
      if (rb_addr[k][7:6] == 2'b01) rb_bus[k][63:32] = mem[k][rb_addr[k]];
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit          busy   [2];
  int          age    [2];   // cycles since acceptance, 1 = cycle after accept
  logic        m_write[2];
  logic [7:0]  m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] exp_rd [2];
  logic [31:0] held   [2];
  logic [31:0] shadow [2][256] = '{default: '0};

  function automatic int resp_age(input int k, input logic w);
    return w ? 2 : lat_of(k) + 1;
  endfunction

  task automatic model_step(input int k);
    if (!rst_n[k]) begin
      busy[k] = 1'b0; age[k] = 0;
      m_write[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0; held[k] = '0; exp_rd[k] = '0;
    end else if (!busy[k]) begin
      if (req_valid[k]) begin
        busy[k] = 1'b1; age[k] = 1;
        m_write[k] = req_write[k]; m_addr[k] = req_addr[k]; m_wdata[k] = req_wdata[k];
        exp_rd[k] = (req_write[k] || req_addr[k][7]) ? 32'h0 : shadow[k][req_addr[k]];
        if (req_write[k] && !req_addr[k][7]) shadow[k][req_addr[k]] = req_wdata[k];
      end
    end else if (age[k] >= resp_age(k, m_write[k]) && rsp_ready[k]) begin
      busy[k] = 1'b0;
      held[k] = exp_rd[k];
    end else begin
      age[k]++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic compare_inst(input int k);
    logic resp_on;
    resp_on = busy[k] && (age[k] >= resp_age(k, m_write[k]));
    chk("req_ready",   k, req_ready[k],   !busy[k]);
    chk("rsp_valid",   k, rsp_valid[k],   resp_on);
    chk("cfg_we",      k, cfg_we[k],      busy[k] && m_write[k] && age[k] == 1);
    chk("cfg_addr",    k, cfg_addr[k],    m_addr[k]);
    chk("cfg_data_in", k, cfg_data_in[k], m_wdata[k]);
    chk("rsp_write",   k, rsp_write[k],   m_write[k]);
    chk("rsp_rdata",   k, rsp_rdata[k],   resp_on ? exp_rd[k] : held[k]);
    if (cfg_we[k] === 1'b1) we_cnt[k]++;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) compare_inst(k);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rdy_rand[k]) rsp_ready[k] = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 with the request driven; returns at acceptance edge+1.
  task automatic wait_accept(input int k);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout inst%0d t=%0t got no req_ready expected req_ready=1", k, $time);
    end else begin
      tick();
    end
  endtask

  // Entered at acceptance edge+1; returns at the negedge where rsp_valid is seen.
  task automatic wait_rsp(input int k, output int lat, output logic [31:0] rd, output logic wr);
    bit ok;
    ok  = 1'b0;
    lat = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rsp_valid[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rsp_timeout inst%0d t=%0t got no rsp_valid expected rsp_valid=1", k, $time);
    end
    rd = rsp_rdata[k];
    wr = rsp_write[k];
  endtask

  task automatic xact(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic wr);
    req_write[k] = w; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1'b1;
    wait_accept(k);
    req_valid[k] = 1'b0;
    wait_rsp(k, lat, rd, wr);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic [31:0] rd;
    logic        wr;
    int          base;
    logic [7:0]  a;

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b1;
      rdy_rand[k] = 1'b0; we_cnt[k] = 0;
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready",   k, req_ready[k],   1);
      chk("rst_rsp_valid",   k, rsp_valid[k],   0);
      chk("rst_rsp_write",   k, rsp_write[k],   0);
      chk("rst_rsp_rdata",   k, rsp_rdata[k],   0);
      chk("rst_cfg_we",      k, cfg_we[k],      0);
      chk("rst_cfg_addr",    k, cfg_addr[k],    0);
      chk("rst_cfg_data_in", k, cfg_data_in[k], 0);
    end
    chk_en = 1'b1;
    tick();

    // Write NUMSAMPLESREG = 0x40 with cycle-exact strobe and response.
    req_write[0] = 1'b1; req_addr[0] = NUMSAMPLESREG; req_wdata[0] = 32'h40; req_valid[0] = 1'b1;
    wait_accept(0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("wr_t1_cfg_we",      0, cfg_we[0],      1);
    chk("wr_t1_cfg_addr",    0, cfg_addr[0],    8'h04);
    chk("wr_t1_cfg_data_in", 0, cfg_data_in[0], 32'h40);
    chk("wr_t1_rsp_valid",   0, rsp_valid[0],   0);
    tick();
    @(negedge clk);
    chk("wr_t2_rsp_valid", 0, rsp_valid[0], 1);
    chk("wr_t2_rsp_write", 0, rsp_write[0], 1);
    chk("wr_t2_rsp_rdata", 0, rsp_rdata[0], 0);
    chk("wr_t2_cfg_we",    0, cfg_we[0],    0);
    chk("bank_numsamples", 0, mem[0][8'h04], 32'h40);
    tick();

    // Write then read SUBVALUEREG, plus a slot-1 register, then an unmapped read.
    xact(0, 1'b1, SUBVALUEREG, 32'h1234, lat, rd, wr);
    chk("wr_sub_lat", 0, lat, 2);
    xact(0, 1'b0, SUBVALUEREG, 32'h0, lat, rd, wr);
    chk("rd_sub_lat",   0, lat, 2);
    chk("rd_sub_rdata", 0, rd,  32'h1234);
    chk("rd_sub_write", 0, wr,  0);
    xact(0, 1'b1, 8'h47, 32'hCAFE0001, lat, rd, wr);
    xact(0, 1'b0, 8'h47, 32'h0, lat, rd, wr);
    chk("rd_slot1_rdata", 0, rd, 32'hCAFE0001);
    xact(0, 1'b0, 8'hFF, 32'h0, lat, rd, wr);
    chk("rd_unmapped_rdata", 0, rd, 32'h0);
    chk("rd_unmapped_write", 0, wr, 0);

    // Response backpressure with a competing request held on the port.
    rsp_ready[0] = 1'b0;
    req_write[0] = 1'b0; req_addr[0] = NUMSAMPLESREG; req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
    wait_accept(0);
    req_write[0] = 1'b1; req_addr[0] = 8'h06; req_wdata[0] = 32'hDEAD;
    wait_rsp(0, lat, rd, wr);
    chk("bp_lat",   0, lat, 2);
    chk("bp_rdata", 0, rd,  32'h40);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_rsp_valid", 0, rsp_valid[0], 1);
      chk("bp_hold_rsp_rdata", 0, rsp_rdata[0], 32'h40);
      chk("bp_hold_req_ready", 0, req_ready[0], 0);
    end
    tick();
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_after_req_ready", 0, req_ready[0], 1);
    chk("bp_after_rsp_valid", 0, rsp_valid[0], 0);
    chk("bp_no_stray_write",  0, mem[0][8'h06], 32'h0);
    tick();

    // Back-to-back writes with req_valid held high.
    base = we_cnt[0];
    req_write[0] = 1'b1; req_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[0]  = 8'(8'h10 + i);
      req_wdata[0] = 32'h100 + i;
      wait_accept(0);
    end
    req_valid[0] = 1'b0;
    repeat (4) tick();
    chk("b2b_we_pulses", 0, we_cnt[0] - base, 4);
    xact(0, 1'b0, 8'h12, 32'h0, lat, rd, wr);
    chk("b2b_readback", 0, rd, 32'h102);

    // RD_LATENCY=3 instance: read timing, then reset during RD_WAIT.
    xact(1, 1'b1, 8'h41, 32'hA5A50041, lat, rd, wr);
    chk("l3_wr_lat", 1, lat, 2);
    xact(1, 1'b0, 8'h41, 32'h0, lat, rd, wr);
    chk("l3_rd_lat",   1, lat, 4);
    chk("l3_rd_rdata", 1, rd,  32'hA5A50041);
    req_write[1] = 1'b0; req_addr[1] = 8'h41; req_valid[1] = 1'b1;
    wait_accept(1);
    req_valid[1] = 1'b0;
    tick();
    rst_n[1] = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_rsp_valid", 1, rsp_valid[1], 0);
    chk("mid_rst_cfg_addr",  1, cfg_addr[1],  0);
    tick();
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", 1, req_ready[1], 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("mid_rst_no_rsp", 1, rsp_valid[1], 0);
    end
    tick();

    // Randomized traffic with random response backpressure.
    for (int k = 0; k < 2; k++) begin
      rdy_rand[k] = 1'b1;
      for (int i = 0; i < 120; i++) begin
        a = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 2) != 0) a = {1'b0, a[6], 3'b000, a[2:0]};
        req_write[k] = 1'($urandom_range(0, 1));
        req_addr[k]  = a;
        req_wdata[k] = $urandom;
        req_valid[k] = 1'b1;
        wait_accept(k);
        req_valid[k] = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      rdy_rand[k]  = 1'b0;
      rsp_ready[k] = 1'b1;
      repeat (10) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog t=%0t got no end of stimulus expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfg_bus_master.md
Name: cfg_bus_master

Overview:
- Initiator side of the register configuration bus (cfg_we / cfg_addr / cfg_data_in) that the sampler register bank responds to.
- Accepts one write or read request at a time from a valid/ready command port and issues the bus cycle.
- For reads, collects readback from the register bank's cfg_data_out lines and returns it on a valid/ready response port.
- Sits between the host/control interface and all reg1cfgw2r-based register banks in the sync block.

Parameters:
- MSB, 31: MSB of the data word; data width is MSB+1.
- MSB_REGS_ADDRESS, 7: MSB of the register address; address width is MSB_REGS_ADDRESS+1.
- NUM_RD, 2: number of readback inputs OR-ed together. Minimum 1.
- RD_LATENCY, 1: cycles from cfg_addr valid to readback valid. Range 1..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  MSB_REGS_ADDRESS+1  register address
- req_wdata  in  MSB+1  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of req_write for this response
- rsp_rdata  out  MSB+1  read data; 0 for writes
- cfg_we  out  1  bus write strobe
- cfg_addr  out  MSB_REGS_ADDRESS+1  bus address
- cfg_data_in  out  MSB+1  bus write data (named from the register bank's viewpoint)
- cfg_data_out_bus  in  NUM_RD*(MSB+1)  concatenated readback words; slot i = bits [(i+1)*(MSB+1)-1 : i*(MSB+1)]

Behaviour:
- Clock and reset: one clock clk. Reset is synchronous and active-low on rst_n. All state is updated on the rising edge of clk.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, cfg_we=0, cfg_addr=0, cfg_data_in=0, wait counter=0.
- Readback convention: each register drives its value on its cfg_data_out when cfg_addr matches its address, and 0 otherwise. Readback word = bitwise OR of all NUM_RD slots. An unmapped address therefore reads 0.
- FSM states: IDLE, WR, RD_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge T: latch addr, wdata and write into cfg_addr, cfg_data_in and rsp_write.
  - If write, go to WR. If read, go to RD_WAIT with counter=RD_LATENCY.
- WR (cycle T+1):
  - cfg_we=1 for exactly this one cycle.
  - Next state RESP with rsp_rdata=0.
- RD_WAIT:
  - cfg_we=0. cfg_addr is held. Counter decrements each cycle.
  - When counter reaches 1, the OR-ed readback is registered into rsp_rdata and the next state is RESP.
  - Read response is asserted RD_LATENCY+1 cycles after acceptance.
- RESP:
  - rsp_valid=1. rsp_write and rsp_rdata are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid drops and state returns to IDLE.
  - req_ready rises in the cycle after the handshake. There is no same-cycle turnaround.
- req_ready=0 in every state except IDLE. Only one transaction is outstanding at a time.
- Write latency: acceptance at T, cfg_we at T+1, rsp_valid at T+2.
- Idle bus: cfg_addr and cfg_data_in keep their last values. cfg_we is never high outside WR.
- Response backpressure: rsp_ready low stalls indefinitely in RESP. Request inputs are ignored during the stall.
- Reset mid-operation:
  - Reset returns to IDLE immediately and drops any pending response.
  - A reset asserted in the cycle before WR suppresses the cfg_we pulse.
  - A reset during WR takes effect at the next edge, so cfg_we ends that cycle.
- req_valid may drop without acceptance only in non-IDLE states, where it has no effect.

Decomposition:
- Shared package sync_params: MSB, MSB_REGS_ADDRESS, register address constants (NUMSAMPLESREG, SUBVALUEREG), and the FSM state encoding localparams (IDLE=0, WR=1, RD_WAIT=2, RESP=3).
- Sub-module cfg_rdback_or: a parameterised NUM_RD-way bitwise OR reduction of the readback bus. Purely combinational, instantiated once.

Test Plan:
- Reset, then write addr=NUMSAMPLESREG, data=0x00000040 -> cfg_we high for 1 cycle at T+1 with cfg_addr=NUMSAMPLESREG and cfg_data_in=0x40. Response rsp_valid at T+2 with rsp_write=1 and rsp_rdata=0. The register bank's reg_data_out0 = 0x40 afterwards.
- Write SUBVALUEREG=0x1234, then read SUBVALUEREG with RD_LATENCY=1 -> rsp_valid 2 cycles after acceptance, rsp_rdata=0x1234, cfg_we stays 0 throughout the read.
- Read an unmapped address 0xFF -> rsp_rdata=0, rsp_write=0.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stay stable, req_ready=0, and a new req_valid is not accepted. Raising rsp_ready completes the handshake and req_ready=1 on the next cycle.
- Back-to-back requests with req_valid held high and rsp_ready=1 -> exactly one cfg_we pulse per write, with one transaction completing before the next is accepted.
- Assert rst_n=0 during RD_WAIT (RD_LATENCY=3) -> the next cycle shows IDLE, rsp_valid=0, cfg_addr=0, no response emitted, and req_ready=1 once rst_n=1.
